// File: rtl/inst_decode_stage.sv
// Registered RV32/RV64 decode stage: splits the instruction into its fields,
// classifies the format, flags illegal encodings, sign-extends the immediate
// and carries the PC. Valid/ready on both sides, flush kills held and
// incoming work, and a saturating counter tallies accepted illegal words.
module inst_decode_stage #(
   parameter int XLEN  = 32,
   parameter int M_EXT = 0,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [XLEN-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [4:0]       rd,
   output logic [6:0]       opcode,
   output logic [2:0]       funct3,
   output logic [6:0]       funct7,
   output logic [XLEN-1:0]  imm,
   output logic [2:0]       instr_type,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_cnt
);

   localparam logic [2:0] TYPE_R   = 3'd0;
   localparam logic [2:0] TYPE_I   = 3'd1;
   localparam logic [2:0] TYPE_S   = 3'd2;
   localparam logic [2:0] TYPE_B   = 3'd3;
   localparam logic [2:0] TYPE_U   = 3'd4;
   localparam logic [2:0] TYPE_J   = 3'd5;
   localparam logic [2:0] TYPE_ILL = 3'd7;

   localparam bit IS_RV64 = (XLEN == 64);
   localparam bit HAS_M   = (M_EXT != 0);

   logic [6:0]      dec_opc;
   logic [2:0]      dec_f3;
   logic [6:0]      dec_f7;
   logic [2:0]      dec_type;
   logic [31:0]     dec_imm32;
   logic [XLEN-1:0] dec_imm;
   logic            accept;

   assign dec_opc = in_instr[6:0];
   assign dec_f3  = in_instr[14:12];
   assign dec_f7  = in_instr[31:25];

   // A new word can enter whenever the output slot is empty or being drained.
   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   // Format classification and 32-bit immediate assembly; anything not
   // matched below stays ILLEGAL with a zero immediate.
   always_comb begin
      dec_type  = TYPE_ILL;
      dec_imm32 = 32'h0;
      if (in_instr[1:0] == 2'b11 && in_instr != 32'h0) begin
         case (dec_opc)
            7'b0110011: begin
               if (dec_f7 == 7'b0000000 ||
                   (dec_f7 == 7'b0100000 && (dec_f3 == 3'b000 || dec_f3 == 3'b101)) ||
                   (HAS_M && dec_f7 == 7'b0000001))
                  dec_type = TYPE_R;
            end
            7'b0010011, 7'b0001111, 7'b1110011: begin
               dec_type  = TYPE_I;
               dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            7'b1100111: begin
               if (dec_f3 == 3'b000) begin
                  dec_type  = TYPE_I;
                  dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
               end
            end
            7'b0000011: begin
               // LD/LWU only exist on RV64; funct3=111 is never a load.
               if (dec_f3 != 3'b111 &&
                   (IS_RV64 || (dec_f3 != 3'b011 && dec_f3 != 3'b110))) begin
                  dec_type  = TYPE_I;
                  dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
               end
            end
            7'b0100011: begin
               if (dec_f3 < 3'b011 || (dec_f3 == 3'b011 && IS_RV64)) begin
                  dec_type  = TYPE_S;
                  dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
               end
            end
            7'b1100011: begin
               if (dec_f3 != 3'b010 && dec_f3 != 3'b011) begin
                  dec_type  = TYPE_B;
                  dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                               in_instr[30:25], in_instr[11:8], 1'b0};
               end
            end
            7'b0110111, 7'b0010111: begin
               dec_type  = TYPE_U;
               dec_imm32 = {in_instr[31:12], 12'h0};
            end
            7'b1101111: begin
               dec_type  = TYPE_J;
               dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                            in_instr[20], in_instr[30:21], 1'b0};
            end
            default: begin
               dec_type  = TYPE_ILL;
               dec_imm32 = 32'h0;
            end
         endcase
      end
   end

   // Bit 31 of the assembled immediate fills the upper half on RV64.
   assign dec_imm = XLEN'($signed(dec_imm32));

   // Output slot: flush empties it, accept fills it, a drain with no refill empties it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Decoded bundle loads only on accept so it holds steady under backpressure.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_pc     <= '0;
         rs1        <= '0;
         rs2        <= '0;
         rd         <= '0;
         opcode     <= '0;
         funct3     <= '0;
         funct7     <= '0;
         imm        <= '0;
         instr_type <= '0;
         illegal    <= 1'b0;
      end else if (accept) begin
         out_pc     <= in_pc;
         rs1        <= in_instr[19:15];
         rs2        <= in_instr[24:20];
         rd         <= in_instr[11:7];
         opcode     <= dec_opc;
         funct3     <= dec_f3;
         funct7     <= dec_f7;
         imm        <= dec_imm;
         instr_type <= dec_type;
         illegal    <= (dec_type == TYPE_ILL);
      end
   end

   // Debug tally of accepted illegal words, pinned at all-ones once full.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegal_cnt <= '0;
      end else if (accept && dec_type == TYPE_ILL && !(&illegal_cnt)) begin
         illegal_cnt <= illegal_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_inst_decode_stage.sv
// Directed bench for inst_decode_stage. Two instances share all inputs:
// dut_a is RV32 without M (CNT_W=16), dut_b is RV64 with M and a 2-bit counter.
module tb_inst_decode_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic [31:0] in_instr;
   logic [63:0] in_pc;
   logic        out_ready;

   logic        a_in_ready, a_out_valid, a_illegal;
   logic [31:0] a_out_pc, a_imm;
   logic [4:0]  a_rs1, a_rs2, a_rd;
   logic [6:0]  a_opcode, a_funct7;
   logic [2:0]  a_funct3, a_type;
   logic [15:0] a_cnt;

   logic        b_in_ready, b_out_valid, b_illegal;
   logic [63:0] b_out_pc, b_imm;
   logic [4:0]  b_rs1, b_rs2, b_rd;
   logic [6:0]  b_opcode, b_funct7;
   logic [2:0]  b_funct3, b_type;
   logic [1:0]  b_cnt;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   inst_decode_stage #(.XLEN(32), .M_EXT(0), .CNT_W(16)) dut_a (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(a_in_ready),
      .in_instr(in_instr), .in_pc(in_pc[31:0]),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_pc(a_out_pc),
      .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd), .opcode(a_opcode),
      .funct3(a_funct3), .funct7(a_funct7), .imm(a_imm),
      .instr_type(a_type), .illegal(a_illegal), .illegal_cnt(a_cnt)
   );

   inst_decode_stage #(.XLEN(64), .M_EXT(1), .CNT_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(b_in_ready),
      .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_pc(b_out_pc),
      .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd), .opcode(b_opcode),
      .funct3(b_funct3), .funct7(b_funct7), .imm(b_imm),
      .instr_type(b_type), .illegal(b_illegal), .illegal_cnt(b_cnt)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [31:0] instr, input logic [63:0] pc);
      in_valid = 1'b1;
      in_instr = instr;
      in_pc    = pc;
   endtask

   initial begin
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
      tick();
      check("rst a_out_valid", 64'(a_out_valid), 64'd0);
      check("rst b_out_valid", 64'(b_out_valid), 64'd0);
      check("rst a_cnt", 64'(a_cnt), 64'd0);
      check("rst b_imm", b_imm, 64'd0);
      rst_n = 1'b1;
      tick();

      // ADDI x1,x0,-1
      present(32'hFFF00093, 64'h1000);
      tick();
      check("addi b_valid", 64'(b_out_valid), 64'd1);
      check("addi b_type", 64'(b_type), 64'd1);
      check("addi b_rd", 64'(b_rd), 64'd1);
      check("addi b_imm", b_imm, 64'hFFFF_FFFF_FFFF_FFFF);
      check("addi b_illegal", 64'(b_illegal), 64'd0);
      check("addi b_pc", b_out_pc, 64'h1000);
      check("addi a_imm", 64'(a_imm), 64'hFFFF_FFFF);

      // BEQ x0,x0,-4, then backpressure with LUI waiting
      present(32'hFE000EE3, 64'h1004);
      tick();
      out_ready = 1'b0;
      present(32'h123450B7, 64'h1008);
      for (int i = 0; i < 3; i++) begin
         #1;
         check("bp a_in_ready", 64'(a_in_ready), 64'd0);
         check("bp a_type", 64'(a_type), 64'd3);
         check("bp a_imm", 64'(a_imm), 64'hFFFF_FFFC);
         check("bp b_imm", b_imm, 64'hFFFF_FFFF_FFFF_FFFC);
         check("bp b_pc", b_out_pc, 64'h1004);
         tick();
      end
      out_ready = 1'b1;
      #1;
      check("release a_in_ready", 64'(a_in_ready), 64'd1);
      tick();
      check("lui a_valid", 64'(a_out_valid), 64'd1);
      check("lui a_type", 64'(a_type), 64'd4);
      check("lui a_imm", 64'(a_imm), 64'h1234_5000);
      check("lui b_pc", b_out_pc, 64'h1008);

      // SW x1,-4(x2) and JAL x1,+8
      present(32'hFE112E23, 64'h100C);
      tick();
      check("sw b_type", 64'(b_type), 64'd2);
      check("sw b_imm", b_imm, 64'hFFFF_FFFF_FFFF_FFFC);
      check("sw b_rs1", 64'(b_rs1), 64'd2);
      check("sw b_rs2", 64'(b_rs2), 64'd1);
      present(32'h008000EF, 64'h1010);
      tick();
      check("jal a_type", 64'(a_type), 64'd5);
      check("jal a_imm", 64'(a_imm), 64'd8);

      // Bubble: no input, downstream ready -> slot empties
      in_valid = 1'b0;
      tick();
      check("bubble a_valid", 64'(a_out_valid), 64'd0);

      // Illegal encodings on dut_a
      present(32'h00000000, 64'h2000);
      tick();
      check("zero a_illegal", 64'(a_illegal), 64'd1);
      check("zero a_type", 64'(a_type), 64'd7);
      check("zero a_imm", 64'(a_imm), 64'd0);
      present(32'h02208033, 64'h2004);
      tick();
      check("mul a_illegal", 64'(a_illegal), 64'd1);
      check("mul a_funct7", 64'(a_funct7), 64'd1);
      check("mul b_type", 64'(b_type), 64'd0);
      check("mul b_illegal", 64'(b_illegal), 64'd0);
      present(32'h0000B083, 64'h2008);
      tick();
      check("ld a_illegal", 64'(a_illegal), 64'd1);
      check("ld a_imm", 64'(a_imm), 64'd0);
      check("ld a_rs1", 64'(a_rs1), 64'd1);
      check("ld a_cnt", 64'(a_cnt), 64'd3);
      check("ld b_type", 64'(b_type), 64'd1);
      check("ld b_cnt", 64'(b_cnt), 64'd1);

      // Flush with an illegal word arriving
      present(32'h00000000, 64'h200C);
      flush = 1'b1;
      tick();
      flush = 1'b0;
      check("flush a_valid", 64'(a_out_valid), 64'd0);
      check("flush a_cnt", 64'(a_cnt), 64'd3);
      check("flush b_cnt", 64'(b_cnt), 64'd1);

      // Five more illegal words: dut_b saturates at 3, dut_a reaches 8
      for (int i = 0; i < 5; i++) begin
         present((i == 2) ? 32'h00000091 : 32'hFFFFFFFF, 64'h3000 + 64'(4 * i));
         tick();
      end
      check("sat b_cnt", 64'(b_cnt), 64'd3);
      check("sat a_cnt", 64'(a_cnt), 64'd8);

      // Hold a word under backpressure, then reset asynchronously mid-cycle
      out_ready = 1'b0;
      in_valid  = 1'b0;
      tick();
      check("hold b_valid", 64'(b_out_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("async a_valid", 64'(a_out_valid), 64'd0);
      check("async b_valid", 64'(b_out_valid), 64'd0);
      check("async a_cnt", 64'(a_cnt), 64'd0);
      check("async b_cnt", 64'(b_cnt), 64'd0);
      tick();
      rst_n = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/inst_decode_stage.md
Name: inst_decode_stage

Overview:
- Registered, parametrised RV32/RV64 instruction-decode pipeline stage with a valid/ready handshake on both sides.
- Extracts register fields, classifies the instruction format and flags illegal encodings.
- Sign-extends the immediate to XLEN and carries the PC alongside the instruction.
- Sits between instruction fetch and register read/execute; supports pipeline flush; keeps a saturating count of illegal instructions for debug.

Parameters:
XLEN, 32, datapath width; 32 or 64 only; sets immediate and PC width
M_EXT, 0, 1 = funct7 0000001 is legal on OP (0110011)
CNT_W, 16, width of illegal-instruction counter

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous kill of held and incoming instruction
in_valid  in  1  fetch presents instruction
in_ready  out  1  stage can accept
in_instr  in  32  raw instruction
in_pc  in  XLEN  PC of in_instr
out_valid  out  1  decoded bundle valid
out_ready  in  1  downstream accepts
out_pc  out  XLEN  registered PC
rs1/rs2/rd  out  5 each  instr[19:15]/[24:20]/[11:7]
opcode  out  7  instr[6:0]
funct3  out  3  instr[14:12]
funct7  out  7  instr[31:25]
imm  out  XLEN  sign-extended immediate
instr_type  out  3  R=0 I=1 S=2 B=3 U=4 J=5 ILLEGAL=7
illegal  out  1  instr_type==ILLEGAL
illegal_cnt  out  CNT_W  saturating count of accepted illegal instructions

Behaviour:
- Reset (async, rst_n low): out_valid=0, every registered data output=0, illegal_cnt=0.
- Reset deassertion is synchronised by the integrator.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational).
  - Transfer in on in_valid && in_ready.
  - Transfer out on out_valid && out_ready.
- Latency: 1 cycle; an accepted instruction appears on the outputs the next cycle.
- Throughput: 1 per cycle while out_ready=1.
- Register update:
  - On accept, all outputs load the decode of in_instr/in_pc and out_valid becomes 1.
  - Outputs hold stable while out_valid && !out_ready.
  - out_valid clears when out_ready=1 and there is no new accept.
- Flush dominates:
  - out_valid<=0 next cycle; any same-cycle input is dropped.
  - illegal_cnt is not incremented for the dropped input.
  - Data registers may hold stale values.
- Classification and immediate, by opcode:
  - 0110011 → R. imm=0. Legal only if funct7 is 0000000, 0100000 with funct3 ∈ {000,101}, or (M_EXT && 0000001).
  - 0010011, 0000011, 1100111, 0001111, 1110011 → I. imm=sext(instr[31:20]).
    - 1100111 requires funct3=000.
    - 0000011 with funct3 ∈ {011,110} is legal only if XLEN=64; funct3=111 is always illegal.
  - 0100011 → S. imm=sext({instr[31:25],instr[11:7]}). funct3 > 011 is illegal; funct3=011 is legal only if XLEN=64.
  - 1100011 → B. imm=sext({instr[31],instr[7],instr[30:25],instr[11:8],0}). funct3 010/011 are illegal.
  - 0110111, 0010111 → U. imm=sext({instr[31:12],12'h0}) to XLEN.
  - 1101111 → J. imm=sext({instr[31],instr[19:12],instr[20],instr[30:21],0}).
  - Any other opcode, instr[1:0]≠11, or in_instr=0 → ILLEGAL, imm=0.
- Sign extension: bit 31 of the assembled immediate is replicated up to XLEN-1. For XLEN=32 this is a no-op.
- illegal_cnt: +1 on each accepted (non-flushed) illegal instruction; saturates at all-ones and does not wrap.
- Field outputs (rs1, rs2, rd, funct3, funct7, opcode) are always raw bit slices, including for illegal instructions.

Test Plan:
- Reset mid-stream: hold out_ready=0 with out_valid=1, assert rst_n=0 asynchronously → out_valid=0 and illegal_cnt=0 immediately, without waiting for a clock edge.
- ADDI x1,x0,-1 (0xFFF00093), XLEN=64, out_ready=1 → next cycle: instr_type=1, rd=1, imm=0xFFFFFFFFFFFFFFFF, illegal=0.
- Backpressure: out_ready=0 for 3 cycles while in_valid=1 with BEQ 0xFE000EE3 → in_ready=0, outputs stable at instr_type=3, imm=0xFFFFFFFC; out_ready=1 → handoff occurs and the next instruction is accepted in the same cycle.
- Illegal encodings: 0x00000000, MUL 0x02208033 with M_EXT=0, and LD 0x0000B083 with XLEN=32 → illegal=1, imm=0, illegal_cnt=3. The same MUL with M_EXT=1 → instr_type=0, illegal=0.
- Flush: in the same cycle an illegal instruction is accepted, assert flush → out_valid=0 next cycle and illegal_cnt unchanged.
- Saturation: CNT_W=2, feed 5 illegal instructions → illegal_cnt=3.
